alu_share_arbiter: RTL and testbench

- Shares one 4-bit ALU (3-bit op_code, operands rs/rt, result rd) between two requesters.
- Round-robin arbitration, valid/ready handshake on each request port, registered operands, and a single-entry result buffer with backpressure.
- Sits between two issuing controllers and the ALU datapath; the ALU function is evaluated inside this block from registered operands.

---
 rtl/alu_share_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one 4-bit ALU between two requesters using round-robin grant and a single-entry result buffer.
// Latency : the result is valid two cycles after the cycle in which reqN_ready is high, then held until taken.
// Backpr. : out_ready low holds the result in DONE; both readies stay low until the buffer drains.
//
// Ports:
//   clk, rst                         clock (rising edge), synchronous active-high reset
//   reqN_valid/reqN_ready            per-requester handshake, N = 0,1
//   reqN_op/reqN_rs/reqN_rt          3-bit op_code and WIDTH-bit operands
//   out_valid/out_ready              result handshake
//   out_rd, out_id                   result value and the requester that issued it
//   busy                             FSM is not IDLE
//   out_zero, out_carry              result flags, present only with ALU_SHARE_FLAGS_EN defined
//
// Optional build macro: ALU_SHARE_FLAGS_EN adds out_zero/out_carry.

module alu_share_arbiter #(
  parameter int WIDTH      = 4,
  parameter int FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_rs,
  input  logic [WIDTH-1:0] req0_rt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_rs,
  input  logic [WIDTH-1:0] req1_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rd,
  output logic             out_id,
  output logic             busy
`ifdef ALU_SHARE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_SHR2 = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // last_grant starts as the requester that should lose the first contention.
  localparam logic LAST_GRANT_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  // The adder keeps its carry bit only when the flag outputs exist.
`ifdef ALU_SHARE_FLAGS_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic             accept0;
  logic             accept1;
  logic             accept;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;
  logic             id_q;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] alu_res;

  // Round-robin: a lone requester always wins; under contention the
  // requester that did not win last time is granted.
  assign grant0  = req0_valid & (~req1_valid | last_grant);
  assign grant1  = req1_valid & (~req0_valid | ~last_grant);
  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;
  assign accept  = accept0 | accept1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        busy       = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ALU on the latched operands. add/sub/inc share one adder so the
  // carry-out means "no borrow" for subtraction.
  always_comb begin
    add_b   = rt_q;
    add_cin = 1'b0;
    case (op_q)
      OP_SUB: begin
        add_b   = ~rt_q;
        add_cin = 1'b1;
      end
      OP_INC: begin
        add_b   = '0;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum  = SW'(rs_q) + SW'(add_b) + SW'(add_cin);
  assign prod = rs_q * rt_q;

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC: alu_res = sum[WIDTH-1:0];
      OP_NOR:                 alu_res = ~(rs_q | rt_q);
      OP_NAND:                alu_res = ~(rs_q & rt_q);
      OP_SHR2:                alu_res = rs_q >> 2;
      OP_SHL1:                alu_res = rs_q << 1;
      OP_MUL:                 alu_res = prod;
      default:                alu_res = '0;
    endcase
  end

  // Operand latch, grant history and the single-entry result buffer.
  // The buffer only loads in EXEC, so it is naturally held throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LAST_GRANT_RST;
      op_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      id_q       <= 1'b0;
      out_rd     <= '0;
      out_id     <= 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q       <= accept1 ? req1_op : req0_op;
        rs_q       <= accept1 ? req1_rs : req0_rs;
        rt_q       <= accept1 ? req1_rt : req0_rt;
        id_q       <= accept1;
        last_grant <= accept1;
      end
      if (state == EXEC) begin
        out_rd    <= alu_res;
        out_id    <= id_q;
`ifdef ALU_SHARE_FLAGS_EN
        out_zero  <= (alu_res == '0);
        out_carry <= (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_INC) ? sum[WIDTH] : 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed self-checking bench for alu_share_arbiter (FIRST_PRIO 0 and 1 instances on shared stimulus).
// Latency : checks are taken 2 time units after each rising edge, once inputs have settled.
// Backpr. : out_ready is driven directly by the stimulus sequence.

module tb_alu_share_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_rs, req0_rt, req1_rs, req1_rt;
  logic       out_ready;

  logic       r0_a, r1_a, ov_a, id_a, busy_a;
  logic [3:0] rd_a;
  logic       r0_b, r1_b, ov_b, id_b, busy_b;
  logic [3:0] rd_b;
`ifdef ALU_SHARE_FLAGS_EN
  logic       z_a, c_a, z_b, c_b;
`endif

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.WIDTH(4), .FIRST_PRIO(0)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_a), .req0_op(req0_op), .req0_rs(req0_rs), .req0_rt(req0_rt),
    .req1_valid(req1_valid), .req1_ready(r1_a), .req1_op(req1_op), .req1_rs(req1_rs), .req1_rt(req1_rt),
    .out_valid(ov_a), .out_ready(out_ready), .out_rd(rd_a), .out_id(id_a), .busy(busy_a)
`ifdef ALU_SHARE_FLAGS_EN
    , .out_zero(z_a), .out_carry(c_a)
`endif
  );

  alu_share_arbiter #(.WIDTH(4), .FIRST_PRIO(1)) u_dut_p1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_b), .req0_op(req0_op), .req0_rs(req0_rs), .req0_rt(req0_rt),
    .req1_valid(req1_valid), .req1_ready(r1_b), .req1_op(req1_op), .req1_rs(req1_rs), .req1_rt(req1_rt),
    .out_valid(ov_b), .out_ready(out_ready), .out_rd(rd_b), .out_id(id_b), .busy(busy_b)
`ifdef ALU_SHARE_FLAGS_EN
    , .out_zero(z_b), .out_carry(c_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_sweep[8] = '{15, 3, 10, 0, 15, 2, 2, 6};

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_rs = 4'd0; req0_rt = 4'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_rs = 4'd0; req1_rt = 4'd0;
    out_ready = 1'b1;
    cyc();
    cyc();
    #1;
    // Reset state
    check("rst_out_valid", int'(ov_a), 0);
    check("rst_out_rd", int'(rd_a), 0);
    check("rst_out_id", int'(id_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_ready0", int'(r0_a), 0);

    // Single op, immediate drain: 7+5=12
    rst = 1'b0;
    cyc();
    req0_valid = 1'b1; req0_op = 3'b000; req0_rs = 4'd7; req0_rt = 4'd5;
    #1;
    check("single_ready0", int'(r0_a), 1);
    check("single_ready1", int'(r1_a), 0);
    check("single_busy_idle", int'(busy_a), 0);
    cyc();
    req0_valid = 1'b0;
    #1;
    check("single_exec_busy", int'(busy_a), 1);
    check("single_exec_ready0", int'(r0_a), 0);
    check("single_exec_valid", int'(ov_a), 0);
    cyc();
    #1;
    check("single_valid", int'(ov_a), 1);
    check("single_rd", int'(rd_a), 12);
    check("single_id", int'(id_a), 0);
    cyc();
    #1;
    check("single_drained", int'(ov_a), 0);
    check("single_busy_end", int'(busy_a), 0);

    // Contention from a fresh reset: FIRST_PRIO picks the first winner
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b001; req0_rs = 4'd3; req0_rt = 4'd5;
    req1_valid = 1'b1; req1_op = 3'b111; req1_rs = 4'd3; req1_rt = 4'd6;
    #1;
    check("prio1_ready1", int'(r1_b), 1);
    check("prio1_ready0", int'(r0_b), 0);
    for (int i = 0; i < 4; i++) begin
      int eid;
      eid = i % 2;
      check($sformatf("alt%0d_ready0", i), int'(r0_a), (eid == 0) ? 1 : 0);
      check($sformatf("alt%0d_ready1", i), int'(r1_a), (eid == 1) ? 1 : 0);
      cyc();
      #1;
      check($sformatf("alt%0d_exec_rdy", i), int'(r0_a | r1_a), 0);
      cyc();
      #1;
      check($sformatf("alt%0d_valid", i), int'(ov_a), 1);
      check($sformatf("alt%0d_id", i), int'(id_a), eid);
      check($sformatf("alt%0d_rd", i), int'(rd_a), (eid == 0) ? 14 : 2);
      check($sformatf("alt%0d_p1_id", i), int'(id_b), 1 - eid);
      cyc();
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: 13>>2 = 3, held for 5 cycles; req1 waits meanwhile
    cyc();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b101; req0_rs = 4'd13; req0_rt = 4'd0;
    req1_valid = 1'b1; req1_op = 3'b000; req1_rs = 4'd1; req1_rt = 4'd1;
    #1;
    check("bp_ready0", int'(r0_a), 1);
    cyc();
    req0_valid = 1'b0;
    #1;
    check("bp_exec_ready1", int'(r1_a), 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_valid", i), int'(ov_a), 1);
      check($sformatf("bp%0d_rd", i), int'(rd_a), 3);
      check($sformatf("bp%0d_ready1", i), int'(r1_a), 0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_valid", int'(ov_a), 1);
    check("bp_release_ready1", int'(r1_a), 0);
    cyc();
    #1;
    check("bp_next_ready1", int'(r1_a), 1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    #1;
    check("bp_next_rd", int'(rd_a), 2);
    check("bp_next_id", int'(id_a), 1);
    cyc();

    // Reset while in EXEC discards the op
    req0_valid = 1'b1; req0_op = 3'b010; req0_rs = 4'd15; req0_rt = 4'd0;
    #1;
    check("rmid_ready0", int'(r0_a), 1);
    cyc();
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rmid_in_exec", int'(busy_a), 1);
    cyc();
    rst = 1'b0;
    #1;
    check("rmid_valid", int'(ov_a), 0);
    check("rmid_rd", int'(rd_a), 0);
    check("rmid_busy", int'(busy_a), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      check($sformatf("rmid_quiet%0d", i), int'(ov_a), 0);
    end

    // Op sweep rs=9 rt=6
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_op = 3'(i); req0_rs = 4'd9; req0_rt = 4'd6;
      #1;
      check($sformatf("sweep%0d_ready", i), int'(r0_a), 1);
      cyc();
      req0_valid = 1'b0;
      cyc();
      #1;
      check($sformatf("sweep%0d_valid", i), int'(ov_a), 1);
      check($sformatf("sweep%0d_rd", i), int'(rd_a), exp_sweep[i]);
      cyc();
    end

`ifdef ALU_SHARE_FLAGS_EN
    // Flags: 8+8 wraps to 0 with carry; 2-3 borrows
    req0_valid = 1'b1; req0_op = 3'b000; req0_rs = 4'd8; req0_rt = 4'd8;
    cyc();
    req0_valid = 1'b0;
    cyc();
    #1;
    check("flag_add_rd", int'(rd_a), 0);
    check("flag_add_zero", int'(z_a), 1);
    check("flag_add_carry", int'(c_a), 1);
    cyc();
    req0_valid = 1'b1; req0_op = 3'b001; req0_rs = 4'd2; req0_rt = 4'd3;
    cyc();
    req0_valid = 1'b0;
    cyc();
    #1;
    check("flag_sub_rd", int'(rd_a), 15);
    check("flag_sub_zero", int'(z_a), 0);
    check("flag_sub_carry", int'(c_a), 0);
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
